// File: rtl/sd_crc_multi.sv
// Multi-lane SD DAT CRC engine: per-lane CRC generation (serial out)
// or checking (compare received CRC) over a fixed-length block.
module sd_crc_multi #(
  parameter int              LANES      = 4,
  parameter int              WIDTH      = 16,
  parameter logic [WIDTH-1:0] POLY      = 16'h1021,
  parameter int              BLOCK_BITS = 1024
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   START,
  input  logic                   MODE,
  input  logic                   BIT_EN,
  input  logic [LANES-1:0]       DIN,
  output logic [LANES-1:0]       DOUT,
  output logic                   DOUT_VALID,
  output logic                   BUSY,
  output logic                   DONE,
  output logic                   CRC_OK,
  output logic [LANES-1:0]       ERR_LANES,
  output logic [LANES*WIDTH-1:0] CRC
);

  localparam int MAXB = (BLOCK_BITS > WIDTH) ? BLOCK_BITS : WIDTH;
  localparam int CW   = $clog2(MAXB + 1);
  localparam logic [CW-1:0] LAST_D = CW'(BLOCK_BITS - 1);
  localparam logic [CW-1:0] LAST_C = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    CRCPH,
    FIN
  } state_e;

  state_e                 state_q;
  logic [LANES*WIDTH-1:0] crc_q;
  logic [CW-1:0]          cnt_q;
  logic                   mode_q;
  logic [LANES-1:0]       err_q;
  logic                   ok_q;
  logic                   done_q;

  logic [LANES*WIDTH-1:0] lfsr_d;
  logic [LANES*WIDTH-1:0] shl_d;
  logic [LANES-1:0]       msb;
  logic [LANES-1:0]       inv;
  logic [LANES-1:0]       err_d;

  always_comb begin
    lfsr_d = '0;
    shl_d  = '0;
    msb    = '0;
    inv    = '0;
    for (int l = 0; l < LANES; l++) begin
      msb[l] = crc_q[l*WIDTH + WIDTH-1];
      inv[l] = DIN[l] ^ msb[l];
      shl_d[l*WIDTH +: WIDTH] =
        {crc_q[l*WIDTH +: WIDTH-1], 1'b0};
      lfsr_d[l*WIDTH +: WIDTH] =
        shl_d[l*WIDTH +: WIDTH] ^ (inv[l] ? POLY : '0);
    end
    // in check mode a differing bit is a mismatch on that lane
    err_d = mode_q ? (err_q | inv) : err_q;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      crc_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      err_q   <= '0;
      ok_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (START) begin
        state_q <= DATA;
        crc_q   <= '0;
        cnt_q   <= '0;
        mode_q  <= MODE;
        err_q   <= '0;
        ok_q    <= 1'b0;
      end else begin
        unique case (state_q)
          DATA: begin
            if (BIT_EN) begin
              crc_q <= lfsr_d;
              if (cnt_q == LAST_D) begin
                cnt_q   <= '0;
                state_q <= CRCPH;
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end
          end
          CRCPH: begin
            if (BIT_EN) begin
              crc_q <= shl_d;
              err_q <= err_d;
              if (cnt_q == LAST_C) begin
                cnt_q   <= '0;
                state_q <= FIN;
                done_q  <= 1'b1;
                ok_q    <= ~|err_d;
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end
          end
          FIN:     state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    DOUT       = '1;
    DOUT_VALID = 1'b0;
    if (state_q == CRCPH && !mode_q) begin
      DOUT       = msb;
      DOUT_VALID = 1'b1;
    end
  end

  assign BUSY      = (state_q != IDLE);
  assign DONE      = done_q;
  assign CRC_OK    = ok_q;
  assign ERR_LANES = err_q;
  assign CRC       = crc_q;

endmodule

// File: doc/sd_crc_multi.md
SD_CRC_MULTI -- requirements
Module: sd_crc_multi

Interface
REQ-001 SHALL have parameter LANES, default 4, number of independent serial data lanes (1 or 4 for SD DAT bus).
REQ-002 SHALL have parameter WIDTH, default 16, CRC register width per lane.
REQ-003 SHALL have parameter POLY, default 16'h1021, generator polynomial without the implicit x^WIDTH term.
REQ-004 SHALL have parameter BLOCK_BITS, default 1024, data bits per lane per block (512-byte block over 4 lanes).
REQ-005 SHALL have port CLK  in  1  single clock; all logic rising-edge.
REQ-006 SHALL have port RESET  in  1  synchronous, active-high reset.
REQ-007 SHALL have port START  in  1  one-cycle pulse: begin new block, latch MODE.
REQ-008 SHALL have port MODE  in  1  0 = generate (send CRC), 1 = check (compare received CRC).
REQ-009 SHALL have port BIT_EN  in  1  bit strobe; one bit per lane is consumed or produced when high.
REQ-010 SHALL have port DIN  in  LANES  serial data/CRC bit per lane.
REQ-011 SHALL have port DOUT  out  LANES  serial CRC bit per lane, MSB first.
REQ-012 SHALL have port DOUT_VALID  out  1  DOUT carries CRC bits.
REQ-013 SHALL have port BUSY  out  1  state is not IDLE.
REQ-014 SHALL have port DONE  out  1  one-cycle pulse at block completion.
REQ-015 SHALL have port CRC_OK  out  1  block result; held until next START.
REQ-016 SHALL have port ERR_LANES  out  LANES  per-lane mismatch flags, held until next START.
REQ-017 SHALL have port CRC  out  LANES*WIDTH  lane l CRC at bits [l*WIDTH +: WIDTH].

Function
REQ-018 SHALL implement states IDLE, DATA, CRCPH, FIN.
REQ-019 SHALL, on START in any state, zero all lane CRCs, counter, ERR_LANES and CRC_OK, latch MODE, and enter DATA next cycle; START has priority over all other events.
REQ-020 SHALL, in DATA with BIT_EN high, per lane: inv = DIN[l] ^ crc[WIDTH-1]; crc <= (crc << 1) ^ (inv ? POLY : 0); counter increments.
REQ-021 SHALL hold all CRCs and counter unchanged when BIT_EN is low (gaps of any length permitted).
REQ-022 SHALL go DATA -> CRCPH on the cycle consuming data bit BLOCK_BITS-1; counter reset to 0.
REQ-023 SHALL, in CRCPH with latched MODE=0, drive DOUT[l] = crc[l][WIDTH-1] combinationally, DOUT_VALID=1, and on BIT_EN shift each crc left with 0 fill.
REQ-024 SHALL, in CRCPH with latched MODE=1, on BIT_EN set ERR_LANES[l] if DIN[l] != crc[l][WIDTH-1], then shift left with 0 fill; flags are sticky.
REQ-025 SHALL go CRCPH -> FIN on the cycle consuming CRC bit WIDTH-1; FIN lasts one cycle, asserts DONE, sets CRC_OK = ~|ERR_LANES (always 1 in MODE=0), then returns to IDLE.
REQ-026 SHALL drive DOUT all-ones and DOUT_VALID=0 outside CRCPH-MODE=0 (SD bus idles high).
REQ-027 SHALL present on CRC the live registers; full computed CRC is valid in the first CRCPH cycle, before any shift.
REQ-028 SHALL size the counter $clog2(max(BLOCK_BITS,WIDTH)+1) bits; no wrap inside a phase.
REQ-029 SHALL ignore BIT_EN and DIN in IDLE and FIN.

Reset
REQ-030 SHALL, on RESET, force IDLE, CRC=0, counter=0, ERR_LANES=0, CRC_OK=0, DONE=0, BUSY=0, DOUT_VALID=0, DOUT all-ones, latched MODE=0; RESET overrides START.
REQ-031 SHALL, on RESET mid-block, discard all partial results; next START begins cleanly.

Verification
REQ-032 SHALL test LANES=1, BLOCK_BITS=4096, MODE=0, 512 bytes 0xFF -> CRC=16'h7FA1 at CRCPH, DOUT emits 0111111110100001, DONE 1 cycle, CRC_OK=1.
REQ-033 SHALL test LANES=4, all-zero block, MODE=1, DIN=0 during CRCPH -> all CRCs 0, ERR_LANES=0, CRC_OK=1.
REQ-034 SHALL test LANES=4, MODE=1, random data, correct CRCs except bit 5 of lane 2 flipped -> ERR_LANES=4'b0100, CRC_OK=0.
REQ-035 SHALL test random BIT_EN gaps (0-7 idle cycles) -> CRC identical to gapless run against bit-serial golden model.
REQ-036 SHALL test RESET asserted mid-DATA, and START mid-CRCPH -> former yields reset values; latter restarts DATA with zero CRCs, no DONE for aborted block.
